rom_streamer: RTL

ROM_STREAMER -- requirements
Module: rom_streamer

---
 rtl/rom_streamer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rom_streamer.sv
// rom_streamer: streams a burst of consecutive words from a combinational ROM onto a valid/ready stream.
// Latency: first beat valid 2 cycles after an accepted start, then one beat per cycle while out_ready=1.
// Backpressure: out_ready=0 stalls ROM fetches; out_data/out_valid/out_last hold until the beat transfers.
// Optional feature: define ROM_STREAMER_CSUM_EN to build the running XOR checksum on csum.
module rom_streamer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  output logic                  rom_ren,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] csum
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;      // next address to fetch
  logic [ADDR_WIDTH:0]   count;     // words still to fetch
  logic [ADDR_WIDTH-1:0] addr_hold; // address of the most recent fetch
  logic                  fetch;
  logic                  xfer;

  // The ROM answers in the same cycle, so the fetch strobe must be combinational:
  // it depends on this cycle's out_ready. Between fetches rom_addr parks on the last address.
  assign fetch    = (state == READ) && (count != '0) && (!out_valid || out_ready);
  assign xfer     = out_valid && out_ready;
  assign rom_ce   = fetch;
  assign rom_ren  = fetch;
  assign rom_addr = fetch ? addr : addr_hold;

  // Burst control FSM with registered stream, busy and done outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      count     <= '0;
      addr_hold <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= start_addr;
            count <= len;
            busy  <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (fetch) begin
            // A fetch both refills the output register and retires any beat being accepted.
            out_data  <= rom_data;
            out_valid <= 1'b1;
            out_last  <= (count == CNT_ONE);
            addr      <= addr + ADDR_ONE;
            count     <= count - CNT_ONE;
            addr_hold <= addr;
          end else if (xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROM_STREAMER_CSUM_EN
  // Running XOR of every transferred beat; cleared when a burst is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (state == READ && xfer) begin
      csum <= csum ^ out_data;
    end
  end
`else
  assign csum = '0;
`endif

endmodule
